// File: rtl/arm_mc_controller.sv
// Multicycle ARM main control FSM: sequences the shared datapath, holds NZCV and gates all write enables.
// Optional ARM_MC_MEMWAIT_EN adds a MemReady input that stalls FETCH/MEMREAD/MEMWRITE until memory is ready.
module arm_mc_controller #(
    parameter int STATE_W = 4,
    parameter int PC_IDX  = 15
) (
    input  logic               clk,
    input  logic               reset,
`ifdef ARM_MC_MEMWAIT_EN
    input  logic               MemReady,
`endif
    input  logic [19:0]        Instr,
    input  logic [3:0]         ALUFlags,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUControl,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic [STATE_W-1:0] State
);
    localparam logic [STATE_W-1:0] FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] EXECR    = STATE_W'(6);
    localparam logic [STATE_W-1:0] EXECI    = STATE_W'(7);
    localparam logic [STATE_W-1:0] ALUWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] BRANCH   = STATE_W'(9);

    logic [STATE_W-1:0] state_reg, state_next;
    logic [3:0]         flags_reg;
    logic [3:0]         cond, rd;
    logic [1:0]         op;
    logic [5:0]         funct;
    logic               mem_ready, cond_ex, no_write, wb_no_write, rd_is_pc, flag_upd;
    logic [1:0]         alu_dec;
    logic               flag_n, flag_z, flag_c, flag_v;
    logic               irwrite_m, pcwrite_m, memwrite_m, regwrite_m, adrsrc_m, alusrca_m;
    logic [1:0]         alusrcb_m, resultsrc_m, alucontrol_m;
    logic               unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

`ifdef ARM_MC_MEMWAIT_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    assign {flag_n, flag_z, flag_c, flag_v} = flags_reg;

    always_comb begin
        case (cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        alu_dec  = 2'b00;
        no_write = 1'b0;
        case (funct[4:1])
            4'b0100: alu_dec = 2'b00;
            4'b0010: alu_dec = 2'b01;
            4'b0000: alu_dec = 2'b10;
            4'b1100: alu_dec = 2'b11;
            4'b1010: begin alu_dec = 2'b01; no_write = 1'b1; end
            default: begin alu_dec = 2'b00; no_write = 1'b1; end
        endcase
    end

    // The funct field only carries an ALU command for data-processing; loads always write back.
    assign wb_no_write = (op == 2'b00) & no_write;
    assign rd_is_pc    = (rd == 4'(PC_IDX));

    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:    state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    2'b00:   state_next = funct[5] ? EXECI : EXECR;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: state_next = mem_ready ? FETCH : MEMWRITE;
            EXECR:    state_next = ALUWB;
            EXECI:    state_next = ALUWB;
            default:  state_next = FETCH;
        endcase
    end

    always_comb begin
        irwrite_m    = 1'b0;
        pcwrite_m    = 1'b0;
        memwrite_m   = 1'b0;
        regwrite_m   = 1'b0;
        adrsrc_m     = 1'b0;
        alusrca_m    = 1'b0;
        alusrcb_m    = 2'b00;
        resultsrc_m  = 2'b00;
        alucontrol_m = 2'b00;
        case (state_reg)
            FETCH: begin
                irwrite_m   = 1'b1;
                pcwrite_m   = 1'b1;
                alusrca_m   = 1'b1;
                alusrcb_m   = 2'b10;
                resultsrc_m = 2'b10;
            end
            DECODE: begin
                alusrca_m   = 1'b1;
                alusrcb_m   = 2'b10;
                resultsrc_m = 2'b10;
            end
            MEMADR:   alusrcb_m = 2'b01;
            MEMREAD:  adrsrc_m = 1'b1;
            MEMWRITE: begin
                adrsrc_m   = 1'b1;
                memwrite_m = cond_ex;
            end
            EXECR:    alucontrol_m = alu_dec;
            EXECI: begin
                alusrcb_m    = 2'b01;
                alucontrol_m = alu_dec;
            end
            MEMWB: begin
                resultsrc_m = 2'b01;
                regwrite_m  = cond_ex & ~rd_is_pc & ~wb_no_write;
                pcwrite_m   = cond_ex & rd_is_pc;
            end
            ALUWB: begin
                regwrite_m = cond_ex & ~rd_is_pc & ~wb_no_write;
                pcwrite_m  = cond_ex & rd_is_pc;
            end
            BRANCH: begin
                alusrcb_m   = 2'b01;
                resultsrc_m = 2'b10;
                pcwrite_m   = cond_ex;
            end
            default: ;
        endcase
    end

    // Reset cycle presents a quiescent FETCH: no writes, fetch-path selects.
    assign IRWrite    = reset & irwrite_m;
    assign PCWrite    = reset & pcwrite_m;
    assign MemWrite   = reset & memwrite_m;
    assign RegWrite   = reset & regwrite_m;
    assign AdrSrc     = reset & adrsrc_m;
    assign ALUSrcA    = reset ? alusrca_m : 1'b1;
    assign ALUSrcB    = reset ? alusrcb_m : 2'b10;
    assign ResultSrc  = reset ? resultsrc_m : 2'b10;
    assign ALUControl = reset ? alucontrol_m : 2'b00;
    assign ImmSrc     = op;
    assign RegSrc     = {op == 2'b01, op == 2'b10};
    assign State      = reset ? state_reg : FETCH;

    assign flag_upd = ((state_reg == EXECR) || (state_reg == EXECI)) && cond_ex && funct[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= FETCH;
            flags_reg <= 4'b0000;
        end else begin
            state_reg <= state_next;
            if (flag_upd) begin
                flags_reg[3:2] <= ALUFlags[3:2];
                if (!alu_dec[1])
                    flags_reg[1:0] <= ALUFlags[1:0];
            end
        end
    end
endmodule

// File: tb/tb_arm_mc_controller.sv
// Self-checking bench for arm_mc_controller: directed instruction sequences plus random instructions
// checked cycle by cycle against an instruction-level reference model.
module tb_arm_mc_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] Instr = 20'h0;
    logic [3:0]  ALUFlags = 4'h0;
`ifdef ARM_MC_MEMWAIT_EN
    logic        MemReady = 1'b1;
    logic        mem_ready_drv = 1'b1;
`endif
    logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
    logic [3:0]  State;

    int          checks = 0;
    int          failures = 0;
    logic [3:0]  m_flags = 4'h0;

    always #5 clk = ~clk;

    arm_mc_controller dut (
        .clk        (clk),
        .reset      (reset),
`ifdef ARM_MC_MEMWAIT_EN
        .MemReady   (MemReady),
`endif
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .State      (State)
    );

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 2'b00;
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            4'b1010: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, then apply the model's flag update.
    task automatic do_cycle(input logic [3:0] exp_state, input logic [31:0] ir, input logic rst_n,
                            input logic [3:0] alu_f);
        logic [3:0] en;
        logic [7:0] sel;
        logic       ok, dest_pc, writes;
        logic [1:0] op;
        logic [3:0] cmd;
        @(posedge clk);
        #1;
        reset    = rst_n;
        Instr    = ir[31:12];
        ALUFlags = alu_f;
`ifdef ARM_MC_MEMWAIT_EN
        MemReady = mem_ready_drv;
`endif
        #3;
        ok      = cond_holds(ir[31:28], m_flags);
        op      = ir[27:26];
        cmd     = ir[24:21];
        dest_pc = (ir[15:12] == 4'd15);
        writes  = (op != 2'b00) || (cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100});
        en      = 4'b0000;
        sel     = 8'h00;
        case (exp_state)
            4'd0: begin en = 4'b1100; sel = {1'b0, 1'b1, 2'b10, 2'b10, 2'b00}; end
            4'd1: sel = {1'b0, 1'b1, 2'b10, 2'b10, 2'b00};
            4'd2: sel = {1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
            4'd3: sel = {1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
            4'd5: begin en = {2'b00, ok, 1'b0}; sel = {1'b1, 1'b0, 2'b00, 2'b00, 2'b00}; end
            4'd6: sel = {1'b0, 1'b0, 2'b00, 2'b00, alu_of(cmd)};
            4'd7: sel = {1'b0, 1'b0, 2'b01, 2'b00, alu_of(cmd)};
            4'd4: begin
                en  = {1'b0, ok && dest_pc, 1'b0, ok && !dest_pc && writes};
                sel = {1'b0, 1'b0, 2'b00, 2'b01, 2'b00};
            end
            4'd8: en = {1'b0, ok && dest_pc, 1'b0, ok && !dest_pc && writes};
            4'd9: begin en = {1'b0, ok, 2'b00}; sel = {1'b0, 1'b0, 2'b01, 2'b10, 2'b00}; end
            default: ;
        endcase
        if (!rst_n) begin
            en  = 4'b0000;
            sel = {1'b0, 1'b1, 2'b10, 2'b10, 2'b00};
        end
        check("state", {4'h0, State}, rst_n ? {4'h0, exp_state} : 8'h00);
        check("enables_ir_pc_mem_reg", {4'h0, IRWrite, PCWrite, MemWrite, RegWrite}, {4'h0, en});
        check("selects_adr_a_b_res_alu", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}, sel);
        check("immsrc_regsrc", {4'h0, ImmSrc, RegSrc}, {4'h0, op, op == 2'b01, op == 2'b10});
        if (!rst_n)
            m_flags = 4'h0;
        else if ((exp_state == 4'd6 || exp_state == 4'd7) && ok && ir[20]) begin
            if (cmd inside {4'b0100, 4'b0010, 4'b1010})
                m_flags = alu_f;
            else if (cmd inside {4'b0000, 4'b1100})
                m_flags[3:2] = alu_f[3:2];
        end
    endtask

    // Full instruction from FETCH; the state path follows the instruction class.
    task automatic run_instr(input logic [31:0] ir, input logic [3:0] exec_f);
        logic [3:0] path[$];
        path.push_back(4'd0);
        path.push_back(4'd1);
        case (ir[27:26])
            2'b00: begin path.push_back(ir[25] ? 4'd7 : 4'd6); path.push_back(4'd8); end
            2'b01: begin
                path.push_back(4'd2);
                if (ir[20]) begin path.push_back(4'd3); path.push_back(4'd4); end
                else path.push_back(4'd5);
            end
            2'b10: path.push_back(4'd9);
            default: ;
        endcase
        foreach (path[i])
            do_cycle(path[i], ir, 1'b1, (path[i] == 4'd6 || path[i] == 4'd7) ? exec_f : 4'($urandom));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [3:0]  c, cmd;
        logic        s;
        int          kind;
        r    = $urandom;
        kind = $urandom_range(0, 5);
        c    = 4'($urandom_range(0, 15));
        case (kind)
            0, 1: begin
                case ($urandom_range(0, 5))
                    0: cmd = 4'b0100;
                    1: cmd = 4'b0010;
                    2: cmd = 4'b0000;
                    3: cmd = 4'b1100;
                    4: cmd = 4'b1010;
                    default: cmd = 4'b0111;
                endcase
                s = (cmd != 4'b0111) && ($urandom_range(0, 1) == 1);
                if (s) c = 4'hE;
                r = {c, 2'b00, (kind == 1), cmd, s, r[19:0]};
            end
            2: r = {c, 8'b0101_1001, r[19:0]};
            3: r = {c, 8'b0101_1000, r[19:0]};
            4: r = {c, 4'b1010, r[23:0]};
            default: r = {c, 2'b11, r[25:0]};
        endcase
        return r;
    endfunction

    initial begin
        // Reset, then ADD immediate
        do_cycle(4'd0, 32'hE2802005, 1'b0, 4'hF);
        do_cycle(4'd0, 32'hE2802005, 1'b0, 4'hF);
        run_instr(32'hE2802005, 4'hF);
        // STR, LDR
        run_instr(32'hE5802064, 4'h0);
        run_instr(32'hE5901000, 4'h0);
        // SUBS sets Z, BEQ taken; SUBS clears, BEQ not taken
        run_instr(32'hE0523003, 4'b0100);
        run_instr(32'h0A000002, 4'h0);
        run_instr(32'hE0523003, 4'b0000);
        run_instr(32'h0A000002, 4'h0);
        // ADDNE suppressed with Z=1, flags kept; ADD to PC
        run_instr(32'hE0523003, 4'b0100);
        run_instr(32'h12811001, 4'b0000);
        run_instr(32'h0A000002, 4'h0);
        run_instr(32'hE280F004, 4'h0);
        // ANDS updates NZ only, C and V survive
        run_instr(32'hE0523003, 4'b0011);
        run_instr(32'hE2110001, 4'b0100);
        run_instr(32'h2A000000, 4'h0);
        run_instr(32'h6A000000, 4'h0);
        run_instr(32'h0A000000, 4'h0);
        // Reset asserted during MEMWRITE aborts the store and clears flags
        run_instr(32'hE0523003, 4'b0100);
        do_cycle(4'd0, 32'hE5802064, 1'b1, 4'h0);
        do_cycle(4'd1, 32'hE5802064, 1'b1, 4'h0);
        do_cycle(4'd2, 32'hE5802064, 1'b1, 4'h0);
        do_cycle(4'd5, 32'hE5802064, 1'b0, 4'h0);
        run_instr(32'h0A000002, 4'h0);
        run_instr(32'h1A000002, 4'h0);
`ifdef ARM_MC_MEMWAIT_EN
        // Memory not ready: FETCH and MEMWRITE hold with strobes asserted
        mem_ready_drv = 1'b0;
        do_cycle(4'd0, 32'hE5802064, 1'b1, 4'h0);
        mem_ready_drv = 1'b1;
        do_cycle(4'd0, 32'hE5802064, 1'b1, 4'h0);
        do_cycle(4'd1, 32'hE5802064, 1'b1, 4'h0);
        do_cycle(4'd2, 32'hE5802064, 1'b1, 4'h0);
        mem_ready_drv = 1'b0;
        for (int i = 0; i < 3; i++)
            do_cycle(4'd5, 32'hE5802064, 1'b1, 4'h0);
        mem_ready_drv = 1'b1;
        do_cycle(4'd5, 32'hE5802064, 1'b1, 4'h0);
        run_instr(32'hE5901000, 4'h0);
`endif
        // Random instruction stream against the model
        for (int n = 0; n < 120; n++)
            run_instr(rand_instr(), 4'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
